// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

   localparam int MULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one multiplier bit per cycle, fixed WIDTH+1 latency.
// Define SEQ_MULTIPLIER_SIGNED_EN for two's complement operands and product.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done,
   output state_t             dbg_state
);

   // Handshake: start is taken only on a clock edge where the FSM is IDLE
   // (busy low); done pulses for one cycle with product valid, and product
   // then holds until the next operation completes.

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_product;
   logic                 r_busy;
   logic                 r_done;

   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [2*WIDTH-1:0]   w_result;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
   logic                 r_neg;

   // Magnitude of the most negative value still fits in WIDTH unsigned bits.
   assign w_a_mag  = multiplicand[WIDTH-1] ? (~multiplicand + 1'b1) : multiplicand;
   assign w_b_mag  = multiplier[WIDTH-1]   ? (~multiplier + 1'b1)   : multiplier;
   assign w_result = r_neg ? (~r_acc + 1'b1) : r_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_neg <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_neg <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
      end
   end
`else
   assign w_a_mag  = multiplicand;
   assign w_b_mag  = multiplier;
   assign w_result = r_acc;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_product <= w_result;
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign product   = r_product;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule
